trng_vn_packer: RTL and testbench
=================================

TRNG_VN_PACKER -- requirements
Module: trng_vn_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, output word width in bits; fixed at 32 in this revision.
REQ-002 SHALL have parameter BYTE_WIDTH, default 8, bits per byte strobe lane.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port en, input, 1, enables collection of raw samples.
REQ-006 SHALL have port raw_bit, input, 1, raw entropy sample.
REQ-007 SHALL have port raw_valid, input, 1, raw_bit valid this cycle.
REQ-008 SHALL have port D, output, WIDTH, packed debiased word (registered).
REQ-009 SHALL have port we, output, 4, per-byte write strobes for the downstream byte-write register (registered).
REQ-010 SHALL have port word_ready, output, 1, full word held in D, awaiting acknowledge.
REQ-011 SHALL have port word_ack, input, 1, consumer acknowledge of full word.
REQ-012 SHALL have port discard_cnt, output, 16, count of discarded equal pairs.

Function
REQ-013 SHALL implement pair FSM with states FIRST (awaiting first bit) and SECOND (first bit stored).
REQ-014 SHALL accept a sample only when raw_valid=1, en=1, word_ready=0 and word_ack=0.
REQ-015 SHALL, in FIRST on accepted sample: store raw_bit, go to SECOND.
REQ-016 SHALL, in SECOND on accepted sample: pair 10 -> output bit 1; pair 01 -> output bit 0; pair 00/11 -> no output, discard_cnt+1; always return to FIRST.
REQ-017 SHALL saturate discard_cnt at 16'hFFFF; no wrap.
REQ-018 SHALL write each output bit to D[bit_cnt] at the edge accepting the second sample, LSB first; bit_cnt increments 0..31.
REQ-019 SHALL assert we[i] for exactly one cycle, in the first cycle D[8i+7] holds its written bit, i.e. same edge that writes bit 8i+7.
REQ-020 SHALL hold we=0 in all other cycles; at most one we bit high per cycle.
REQ-021 SHALL set word_ready=1 at the edge writing bit 31 (concurrent with we[3] pulse).
REQ-022 SHALL, while word_ready=1, ignore raw samples, hold D, keep FSM in FIRST.
REQ-023 SHALL, when word_ack=1 and word_ready=1: clear word_ready, D to 0, bit_cnt to 0 next edge; word_ack with word_ready=0 has no effect.
REQ-024 SHALL give word_ack priority over raw_valid in the same cycle; that sample is dropped.
REQ-025 SHALL, when en=0: force FSM to FIRST (stored first bit lost), retain D, bit_cnt, word_ready, discard_cnt.
REQ-026 SHALL not count pairs broken by en=0 as discards.

Reset
REQ-027 SHALL, on rst=1 at any edge, set D=0, we=0, word_ready=0, discard_cnt=0, bit_cnt=0, FSM=FIRST; rst overrides all other inputs including mid-word and mid-pair.

Verification
REQ-028 Byte pack: en=1, pairs 10,01,10,01,01,10,01,10 -> D[7:0]=8'hA5 with we=4'b0001 for one cycle at the 8th output bit; discard_cnt=0.
REQ-029 Discard: pairs 00,11,00 -> discard_cnt=3, D unchanged, we=0 throughout.
REQ-030 Full word: 32 pairs of 10 -> D=32'hFFFFFFFF, we pulses 0001,0010,0100,1000 in order, word_ready=1 with we[3]; extra samples ignored until word_ack; after ack D=0, word_ready=0.
REQ-031 Ack collision: word_ready=1, word_ack=1 and raw_valid=1 same cycle -> sample dropped, next accepted pair lands in D[0].
REQ-032 en drop: first bit 1, en=0 one cycle, then pair 01 -> output bit 0 at D[bit_cnt], no discard increment.
REQ-033 Reset mid-word: 12 bits packed, rst=1 one cycle -> D=0, word_ready=0, discard_cnt=0, next output bit at D[0].

Source files
------------

// File: rtl/trng_vn_packer.sv
// Von Neumann debiaser for a raw entropy bit stream. It packs the debiased bits
// LSB first into a word and pulses a byte-lane write strobe as each byte completes.
module trng_vn_packer #(
  parameter int WIDTH      = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             raw_bit,
  input  logic             raw_valid,
  output logic [WIDTH-1:0] D,
  output logic [3:0]       we,
  output logic             word_ready,
  input  logic             word_ack,
  output logic [15:0]      discard_cnt
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {
    FIRST  = 1'b0,
    SECOND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               first_bit_q, first_bit_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               word_ready_q, word_ready_d;
  logic [15:0]        discard_q, discard_d;
  logic [3:0]         we_q, we_d;

  logic               accept;
  logic               ack_take;
  logic               bit_valid;
  logic               bit_val;
  logic               pair_discard;

  // An acknowledge in the same cycle always wins; that raw sample is simply lost.
  assign accept   = raw_valid & en & ~word_ready_q & ~word_ack;
  assign ack_take = word_ack & word_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FIRST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en || word_ready_q) begin
      state_d = FIRST;
    end else if (accept) begin
      state_d = (state_q == FIRST) ? SECOND : FIRST;
    end
  end

  always_comb begin
    bit_valid    = 1'b0;
    bit_val      = first_bit_q;
    pair_discard = 1'b0;
    if (accept && state_q == SECOND) begin
      if (first_bit_q != raw_bit) begin
        bit_valid = 1'b1;
      end else begin
        pair_discard = 1'b1;
      end
    end
  end

  always_comb begin
    first_bit_d = first_bit_q;
    if (accept && state_q == FIRST) begin
      first_bit_d = raw_bit;
    end
  end

  always_comb begin
    d_d          = d_q;
    bit_cnt_d    = bit_cnt_q;
    word_ready_d = word_ready_q;
    if (ack_take) begin
      d_d          = '0;
      bit_cnt_d    = '0;
      word_ready_d = 1'b0;
    end else if (bit_valid) begin
      d_d[bit_cnt_q] = bit_val;
      bit_cnt_d      = bit_cnt_q + 1'b1;
      if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
        word_ready_d = 1'b1;
      end
    end
  end

  always_comb begin
    discard_d = discard_q;
    if (pair_discard && discard_q != 16'hFFFF) begin
      discard_d = discard_q + 16'd1;
    end
  end

  // A lane strobe fires on the edge that writes the top bit of that byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane_we
    assign we_d[gi] = bit_valid &&
                      (bit_cnt_q == CNT_W'(gi * BYTE_WIDTH + BYTE_WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_bit_q  <= 1'b0;
      d_q          <= '0;
      bit_cnt_q    <= '0;
      word_ready_q <= 1'b0;
      discard_q    <= '0;
      we_q         <= '0;
    end else begin
      first_bit_q  <= first_bit_d;
      d_q          <= d_d;
      bit_cnt_q    <= bit_cnt_d;
      word_ready_q <= word_ready_d;
      discard_q    <= discard_d;
      we_q         <= we_d;
    end
  end

  assign D           = d_q;
  assign we          = we_q;
  assign word_ready  = word_ready_q;
  assign discard_cnt = discard_q;

endmodule

// File: tb/tb_trng_vn_packer.sv
// Randomised and directed bench for trng_vn_packer, checked against a
// pair-level behavioural model evaluated every cycle.
module tb_trng_vn_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        raw_bit = 1'b0;
  logic        raw_valid = 1'b0;
  logic        word_ack = 1'b0;
  logic [31:0] D;
  logic [3:0]  we;
  logic        word_ready;
  logic [15:0] discard_cnt;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  trng_vn_packer #(.WIDTH(32), .BYTE_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .raw_bit(raw_bit), .raw_valid(raw_valid),
    .D(D), .we(we), .word_ready(word_ready), .word_ack(word_ack),
    .discard_cnt(discard_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: tracks whether half a pair is pending and where the next bit goes.
  logic [31:0] m_d = '0;
  logic [3:0]  m_we = '0;
  bit          m_ready = 1'b0;
  int          m_cnt = 0;
  int          m_disc = 0;
  bit          m_have = 1'b0;
  bit          m_first = 1'b0;

  always @(posedge clk) begin
    m_we = '0;
    if (rst) begin
      m_d = '0; m_ready = 0; m_cnt = 0; m_disc = 0; m_have = 0;
    end else begin
      if (!en) m_have = 0;
      if (word_ack && m_ready) begin
        m_ready = 0; m_d = '0; m_cnt = 0;
      end else if (raw_valid && en && !m_ready && !word_ack) begin
        if (!m_have) begin
          m_first = raw_bit; m_have = 1;
        end else begin
          m_have = 0;
          if (m_first != raw_bit) begin
            m_d[m_cnt] = m_first;
            if (m_cnt % 8 == 7) m_we = 4'(1 << (m_cnt / 8));
            if (m_cnt == 31) m_ready = 1;
            m_cnt = m_cnt + 1;
          end else if (m_disc < 65535) begin
            m_disc = m_disc + 1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("model_D", D, m_d);
      chk("model_we", {28'd0, we}, {28'd0, m_we});
      chk("model_ready", {31'd0, word_ready}, {31'd0, m_ready});
      chk("model_discard", {16'd0, discard_cnt}, 32'(m_disc));
    end
  end

  task automatic cyc(input bit r, input bit e, input bit b, input bit v, input bit a);
    rst = r; en = e; raw_bit = b; raw_valid = v; word_ack = a;
    @(posedge clk);
    #1;
    $display("cyc rst=%0b en=%0b bit=%0b valid=%0b ack=%0b -> D=%h we=%b rdy=%0b disc=%0d",
             r, e, b, v, a, D, we, word_ready, discard_cnt);
  endtask

  task automatic pair(input bit a, input bit b);
    cyc(0, 1, a, 1, 0);
    cyc(0, 1, b, 1, 0);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0);
  endtask

  logic [15:0] pat;
  logic [3:0]  exp_we;

  initial begin
    do_reset();
    checking = 1'b1;
    chk("reset_D", D, 32'd0);
    chk("reset_we", {28'd0, we}, 32'd0);
    chk("reset_ready", {31'd0, word_ready}, 32'd0);
    chk("reset_discard", {16'd0, discard_cnt}, 32'd0);

    // Byte pack: 10,01,10,01,01,10,01,10 gives A5
    pat = 16'b10_01_10_01_01_10_01_10;
    for (int k = 0; k < 8; k++) begin
      pair(pat[15-2*k], pat[14-2*k]);
      if (k < 7) chk("byte_we_quiet", {28'd0, we}, 32'd0);
    end
    chk("byte_we", {28'd0, we}, 32'd1);
    chk("byte_D", D, 32'h0000_00A5);
    chk("byte_disc", {16'd0, discard_cnt}, 32'd0);
    cyc(0, 1, 0, 0, 0);
    chk("byte_we_one_cycle", {28'd0, we}, 32'd0);

    // Discards
    pair(0, 0); pair(1, 1); pair(0, 0);
    chk("disc_cnt", {16'd0, discard_cnt}, 32'd3);
    chk("disc_D", D, 32'h0000_00A5);
    chk("disc_we", {28'd0, we}, 32'd0);

    // en drop loses the stored first bit
    do_reset();
    pair(1, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 0, 0, 0, 0);
    pair(0, 1);
    pair(1, 0);
    chk("endrop_D", D, 32'h0000_0005);
    chk("endrop_disc", {16'd0, discard_cnt}, 32'd0);

    // Full word and strobe order
    do_reset();
    for (int k = 0; k < 32; k++) begin
      pair(1, 0);
      exp_we = (k % 8 == 7) ? 4'(1 << (k / 8)) : 4'd0;
      chk("word_we", {28'd0, we}, {28'd0, exp_we});
      if (k == 30) chk("word_ready_early", {31'd0, word_ready}, 32'd0);
    end
    chk("word_ready", {31'd0, word_ready}, 32'd1);
    chk("word_D", D, 32'hFFFF_FFFF);
    pair(0, 1); pair(0, 1);
    chk("word_hold_D", D, 32'hFFFF_FFFF);
    cyc(0, 1, 0, 0, 1);
    chk("ack_D", D, 32'd0);
    chk("ack_ready", {31'd0, word_ready}, 32'd0);

    // Ack collides with a raw sample: the sample is dropped
    for (int k = 0; k < 32; k++) pair(1, 0);
    cyc(0, 1, 0, 1, 1);
    pair(1, 0);
    chk("collide_D", D, 32'd1);

    // Reset in the middle of a word
    for (int k = 0; k < 12; k++) pair(k[0], !k[0]);
    cyc(0, 1, 1, 1, 0);
    do_reset();
    chk("midrst_D", D, 32'd0);
    chk("midrst_ready", {31'd0, word_ready}, 32'd0);
    chk("midrst_disc", {16'd0, discard_cnt}, 32'd0);
    pair(1, 0);
    chk("midrst_next", D, 32'd1);

    // Random traffic against the model
    for (int n = 0; n < 6000; n++) begin
      cyc($urandom_range(0, 999) == 0,
          $urandom_range(0, 99) < 92,
          1'($urandom),
          $urandom_range(0, 99) < 75,
          word_ready ? ($urandom_range(0, 99) < 10) : ($urandom_range(0, 99) < 2));
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
